// File: rtl/vga_pkg.sv
// vga_pkg: resolution, raster timing and colour-width constants.
// Macros: VGA_640_480 / VGA_320_240 pick the mode (default 160x120); FB_COLOR12_EN selects 12-bit storage.
package vga_pkg;

`ifdef VGA_640_480
  localparam int nX   = 10;
  localparam int COLS = 640;
  localparam int ROWS = 480;
  localparam int Mn   = 19;
  localparam int S    = 0;
  localparam int SH_A = 9;
  localparam int SH_B = 7;
`elsif VGA_320_240
  localparam int nX   = 9;
  localparam int COLS = 320;
  localparam int ROWS = 240;
  localparam int Mn   = 17;
  localparam int S    = 1;
  localparam int SH_A = 8;
  localparam int SH_B = 6;
`else
  localparam int nX   = 8;
  localparam int COLS = 160;
  localparam int ROWS = 120;
  localparam int Mn   = 15;
  localparam int S    = 2;
  localparam int SH_A = 7;
  localparam int SH_B = 5;
`endif
  localparam int nY = nX - 1;

  typedef logic [9:0] cnt_t;

  localparam cnt_t H_VIS  = 10'd640;
  localparam cnt_t H_FP   = 10'd16;
  localparam cnt_t H_SYNC = 10'd96;
  localparam cnt_t H_BP   = 10'd48;
  localparam cnt_t H_SBEG = H_VIS + H_FP;
  localparam cnt_t H_SEND = H_SBEG + H_SYNC;
  localparam cnt_t H_TOT  = H_SEND + H_BP;

  localparam cnt_t V_VIS  = 10'd480;
  localparam cnt_t V_FP   = 10'd10;
  localparam cnt_t V_SYNC = 10'd2;
  localparam cnt_t V_BP   = 10'd33;
  localparam cnt_t V_SBEG = V_VIS + V_FP;
  localparam cnt_t V_SEND = V_SBEG + V_SYNC;
  localparam cnt_t V_TOT  = V_SEND + V_BP;

`ifdef FB_COLOR12_EN
  localparam int CW = 12;
`else
  localparam int CW = 24;
`endif

  typedef logic [Mn-1:0] addr_t;
  typedef logic [CW-1:0] pix_t;

  // row*COLS as two shifts plus the column
  function automatic addr_t lin_addr(addr_t row, addr_t col);
    return (row << SH_A) + (row << SH_B) + col;
  endfunction

  function automatic pix_t pack_color(logic [23:0] c);
`ifdef FB_COLOR12_EN
    return {c[23:20], c[15:12], c[7:4]};
`else
    return c;
`endif
  endfunction

  function automatic logic [23:0] unpack_color(pix_t p);
`ifdef FB_COLOR12_EN
    return {{2{p[11:8]}}, {2{p[7:4]}}, {2{p[3:0]}}};
`else
    return p;
`endif
  endfunction

endpackage

// File: rtl/vga_framebuffer_if.sv
// vga_framebuffer_if: pixel-plot bus (VGA_X, VGA_Y, VGA_COLOR, plot).
// master drives a plot every cycle it holds plot high; slave is the framebuffer.
interface vga_framebuffer_if;
  import vga_pkg::*;

  logic [nX-1:0] VGA_X;
  logic [nY-1:0] VGA_Y;
  logic [23:0]   VGA_COLOR;
  logic          plot;

  modport master (output VGA_X, VGA_Y, VGA_COLOR, plot);
  modport slave  (input  VGA_X, VGA_Y, VGA_COLOR, plot);
endinterface

// File: rtl/vga_raster_timing.sv
// vga_raster_timing: 25 MHz enable, 800x525 counters, raw sync/visible.
// Ports: clk_i, rst_i in; pix_en_o, hcount_o, vcount_o, hs_o, vs_o, vis_o out.
module vga_raster_timing
  import vga_pkg::*;
(
  input  logic clk_i,
  input  logic rst_i,
  output logic pix_en_o,
  output cnt_t hcount_o,
  output cnt_t vcount_o,
  output logic hs_o,
  output logic vs_o,
  output logic vis_o
);

  logic pix_en_q;
  cnt_t h_q, h_d;
  cnt_t v_q, v_d;

  always_comb begin
    h_d = h_q;
    v_d = v_q;
    if (pix_en_q) begin
      if (h_q == H_TOT - 10'd1) begin
        h_d = '0;
        v_d = (v_q == V_TOT - 10'd1) ? '0 : v_q + 10'd1;
      end else begin
        h_d = h_q + 10'd1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pix_en_q <= 1'b0;
      h_q      <= '0;
      v_q      <= '0;
    end else begin
      pix_en_q <= ~pix_en_q;
      h_q      <= h_d;
      v_q      <= v_d;
    end
  end

  assign pix_en_o = pix_en_q;
  assign hcount_o = h_q;
  assign vcount_o = v_q;
  assign hs_o     = !(h_q >= H_SBEG && h_q < H_SEND);
  assign vs_o     = !(v_q >= V_SBEG && v_q < V_SEND);
  assign vis_o    = (h_q < H_VIS) && (v_q < V_VIS);

endmodule

// File: rtl/vga_framebuffer.sv
// vga_framebuffer: plot-port video memory scanned out as 640x480@60 VGA.
// Ports: CLOCK_50, Reset, pix (plot bus slave); VGA_R/G/B, VGA_HS/VS, VGA_BLANK_N, VGA_CLK.
module vga_framebuffer
  import vga_pkg::*;
#(
  parameter INIT_FILE = "black.mif"
) (
  input  logic             CLOCK_50,
  input  logic             Reset,
  vga_framebuffer_if.slave pix,
  output logic [7:0]       VGA_R,
  output logic [7:0]       VGA_G,
  output logic [7:0]       VGA_B,
  output logic             VGA_HS,
  output logic             VGA_VS,
  output logic             VGA_BLANK_N,
  output logic             VGA_CLK
);

  logic pix_en;
  cnt_t hcount, vcount;
  logic hs_raw, vs_raw, vis_raw;

  vga_raster_timing u_timing (
    .clk_i    (CLOCK_50),
    .rst_i    (Reset),
    .pix_en_o (pix_en),
    .hcount_o (hcount),
    .vcount_o (vcount),
    .hs_o     (hs_raw),
    .vs_o     (vs_raw),
    .vis_o    (vis_raw)
  );

  // Contents are preloaded by the FPGA memory-init flow, never by Reset.
  (* ram_init_file = INIT_FILE *)
  pix_t  mem_q [COLS*ROWS];
  pix_t  rd_q;
  addr_t waddr, raddr;
  logic  we;

  assign we = pix.plot
           && (pix.VGA_X < nX'(COLS))
           && (pix.VGA_Y < nY'(ROWS));

  assign waddr = lin_addr(addr_t'(pix.VGA_Y),
                          addr_t'(pix.VGA_X));

  // Blanking-time addresses would run past the array; park them at 0.
  assign raddr = vis_raw
    ? lin_addr(addr_t'(vcount >> S), addr_t'(hcount >> S))
    : '0;

  // Read sees pre-write data on an address collision.
  always_ff @(posedge CLOCK_50) begin
    if (we) mem_q[waddr] <= pack_color(pix.VGA_COLOR);
    rd_q <= mem_q[raddr];
  end

  logic        hs1_q, vs1_q, vis1_q;
  logic        hs_q, vs_q, bn_q;
  logic [23:0] rgb_q, rgb_d;

  assign rgb_d = vis1_q ? unpack_color(rd_q) : 24'h0;

  // Sync/blank follow the same two stages as colour.
  always_ff @(posedge CLOCK_50) begin
    if (Reset) begin
      hs1_q  <= 1'b1;
      vs1_q  <= 1'b1;
      vis1_q <= 1'b0;
      hs_q   <= 1'b1;
      vs_q   <= 1'b1;
      bn_q   <= 1'b0;
      rgb_q  <= '0;
    end else begin
      hs1_q  <= hs_raw;
      vs1_q  <= vs_raw;
      vis1_q <= vis_raw;
      hs_q   <= hs1_q;
      vs_q   <= vs1_q;
      bn_q   <= vis1_q;
      rgb_q  <= rgb_d;
    end
  end

  assign VGA_R       = rgb_q[23:16];
  assign VGA_G       = rgb_q[15:8];
  assign VGA_B       = rgb_q[7:0];
  assign VGA_HS      = hs_q;
  assign VGA_VS      = vs_q;
  assign VGA_BLANK_N = bn_q;
  assign VGA_CLK     = pix_en;

endmodule

// File: tb/tb_vga_framebuffer.sv
// tb_vga_framebuffer: random plots checked against a pixel-position model
// of the VGA raster; covers reset, write gating, scan-out and mid-frame reset.
module tb_vga_framebuffer;
  import vga_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #10 clk = ~clk;

  vga_framebuffer_if pif ();

  logic [7:0] r, g, b;
  logic hs, vs, bn, vclk;

  vga_framebuffer dut (
    .CLOCK_50    (clk),
    .Reset       (rst),
    .pix         (pif),
    .VGA_R       (r),
    .VGA_G       (g),
    .VGA_B       (b),
    .VGA_HS      (hs),
    .VGA_VS      (vs),
    .VGA_BLANK_N (bn),
    .VGA_CLK     (vclk)
  );

  int errors = 0;
  int checks = 0;
  logic [23:0] ref_mem [COLS*ROWS];

  localparam logic [27:0] RST_PINS = {1'b1, 1'b1, 1'b0, 1'b0, 24'h0};

  function automatic logic [23:0] shown(logic [23:0] c);
`ifdef FB_COLOR12_EN
    return {{2{c[23:20]}}, {2{c[15:12]}}, {2{c[7:4]}}};
`else
    return c;
`endif
  endfunction

  // Pins after the k-th clock edge following reset release.
  function automatic logic [27:0] exp_pins(int k);
    int pos, h, v;
    logic vis, hsx, vsx;
    logic [23:0] c;
    if (k < 2) return {1'b1, 1'b1, 1'b0, 1'b1, 24'h0};
    pos = (k - 2) / 2;
    h   = pos % 800;
    v   = (pos / 800) % 525;
    vis = (h < 640) && (v < 480);
    hsx = !(h >= 656 && h <= 751);
    vsx = !(v >= 490 && v <= 491);
    c   = vis ? shown(ref_mem[(v >> S) * COLS + (h >> S)]) : 24'h0;
    return {hsx, vsx, vis, k[0], c};
  endfunction

  function automatic logic [27:0] pins();
    return {hs, vs, bn, vclk, r, g, b};
  endfunction

  task automatic check(string tag, logic [27:0] obs, logic [27:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(int x, int y, logic [23:0] c, logic p);
    pif.VGA_X     = nX'(x);
    pif.VGA_Y     = nY'(y);
    pif.VGA_COLOR = c;
    pif.plot      = p;
  endtask

  task automatic scan(string tag, int n);
    for (int k = 1; k <= n; k++) begin
      step();
      check(tag, pins(), exp_pins(k));
    end
  endtask

  initial begin
    logic [23:0] c;
    int fill_rows;
    fill_rows = 16 >> S;
    drive(0, 0, 24'h0, 1'b0);

    rst = 1'b1;
    repeat (3) begin
      step();
      check("reset", pins(), RST_PINS);
    end

    rst = 1'b0;
    for (int y = 0; y < fill_rows; y++) begin
      for (int x = 0; x < COLS; x++) begin
        if ($urandom_range(0, 3) == 0) begin
          drive(x, y, $urandom, 1'b0);
          step();
        end
        if ($urandom_range(0, 3) == 0) begin
          if ($urandom_range(0, 1) == 0)
            drive($urandom_range(COLS, 2**nX - 1), y, $urandom, 1'b1);
          else
            drive(x, $urandom_range(ROWS, 2**nY - 1), $urandom, 1'b1);
          step();
        end
        c = $urandom;
        drive(x, y, c, 1'b1);
        ref_mem[y * COLS + x] = c;
        step();
      end
    end
    drive(COLS, 0, 24'hFFFFFF, 1'b1);
    step();
    drive(0, 0, 24'hFF0000, 1'b1);
    ref_mem[0] = 24'hFF0000;
    step();
    drive(1, 0, 24'h12AB7F, 1'b1);
    ref_mem[1] = 24'h12AB7F;
    step();

    rst = 1'b1;
    c = $urandom;
    drive(7, 1, c, 1'b1);
    ref_mem[COLS + 7] = c;
    step();
    check("reset_wr", pins(), RST_PINS);
    pif.plot = 1'b0;
    repeat (2) begin
      step();
      check("reset", pins(), RST_PINS);
    end

    rst = 1'b0;
    scan("scan", 12 * 1600 + $urandom_range(0, 1599));

    rst = 1'b1;
    step();
    check("rst_mid", pins(), RST_PINS);
    rst = 1'b0;
    scan("rescan", 12 * 1600);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
